// File: rtl/router_pkg.sv
// Shared widths, FSM state type and FIFO entry layout for the router ingress path.
package router_pkg;

   localparam int ADDR_W = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      PAD,
      DATA
   } rx_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BYTE_W-1:0] data;
      logic              last;
      logic              err;
   } rx_entry_t;

endpackage

// File: rtl/router_input_deserializer_if.sv
// Byte-stream handshake from the ingress deserializer toward the switching core.
interface router_input_deserializer_if;
   import router_pkg::*;

   logic [ADDR_W-1:0] out_addr;
   logic [BYTE_W-1:0] out_data;
   logic              out_last;
   logic              out_err;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_addr, out_data, out_last, out_err, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_addr, out_data, out_last, out_err, out_valid,
      output out_ready
   );

endinterface

// File: rtl/router_byte_fifo.sv
// Synchronous show-ahead FIFO of rx_entry_t; simultaneous push/pop allowed at any fill level.
module router_byte_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  rx_entry_t              wr_entry,
   input  logic                   rd_en,
   output rx_entry_t              rd_entry,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rx_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   always_comb begin
      empty    = (count == '0);
      full     = (count == CNT_W'(DEPTH));
      do_rd    = rd_en & ~empty;
      do_wr    = wr_en & (~full | do_rd);
      rd_entry = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/router_input_deserializer.sv
// Per-port ingress: decodes the bit-serial frame, assembles LSB-first bytes and queues
// them with address/last/err tags toward the switching core.
module router_input_deserializer
   import router_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int PAD_CYCLES = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        din,
   input  logic                        frame_n,
   input  logic                        valid_n,
   router_input_deserializer_if.master rx,
   output logic                        busy,
   output logic                        err_protocol,
   output logic                        err_overflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int BIT_W = $clog2(BYTE_W);

   rx_state_e         state_q, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [BYTE_W-1:0] sh_q, sh_n;
   logic [BIT_W-1:0]  bit_q, bit_n;
   logic [7:0]        ph_q, ph_n;
   logic              drop_q, drop_n;
   logic              wr_q, wr_n;
   rx_entry_t         wre_q, wre_n;
   logic              perr_n, oerr_n;

   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  occ;
   logic              empty;
   rx_entry_t         head;
   rx_entry_t         out_e;
   logic [BYTE_W-1:0] byte_nxt;

   // The registered write is not yet in count, so fill checks include it.
   always_comb begin
      occ      = count + CNT_W'(wr_q);
      byte_nxt = sh_q | (BYTE_W'(din) << bit_q);
   end

   always_comb begin
      state_n = state_q;
      addr_n  = addr_q;
      sh_n    = sh_q;
      bit_n   = bit_q;
      ph_n    = ph_q;
      drop_n  = drop_q;
      wr_n    = 1'b0;
      wre_n   = '0;
      perr_n  = 1'b0;
      oerr_n  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!frame_n) begin
               state_n = ADDR;
               addr_n  = {din, addr_q[ADDR_W-1:1]};
               ph_n    = '0;
               sh_n    = '0;
               bit_n   = '0;
               drop_n  = 1'b0;
            end
         end

         ADDR: begin
            if (frame_n) begin
               perr_n  = 1'b1;
               state_n = IDLE;
            end else begin
               addr_n = {din, addr_q[ADDR_W-1:1]};
               if (ph_q == 8'(ADDR_W - 2)) begin
                  ph_n    = '0;
                  state_n = (PAD_CYCLES == 0) ? DATA : PAD;
               end else begin
                  ph_n = ph_q + 8'd1;
               end
            end
         end

         PAD: begin
            if (frame_n) begin
               perr_n  = 1'b1;
               state_n = IDLE;
            end else if (ph_q == 8'(PAD_CYCLES - 1)) begin
               state_n = DATA;
            end else begin
               ph_n = ph_q + 8'd1;
            end
         end

         DATA: begin
            if (!valid_n) begin
               if (frame_n) begin
                  state_n = IDLE;
                  if (occ < CNT_W'(DEPTH)) begin
                     wr_n       = 1'b1;
                     wre_n.addr = addr_q;
                     wre_n.data = byte_nxt;
                     wre_n.last = 1'b1;
                     wre_n.err  = (bit_q != '1) | drop_q;
                  end else if (!drop_q) begin
                     oerr_n = 1'b1;
                  end
               end else begin
                  bit_n = bit_q + BIT_W'(1);
                  if (bit_q == '1) begin
                     sh_n = '0;
                     // One slot is held back so a packet with stored bytes can always terminate.
                     if (!drop_q) begin
                        if (occ < CNT_W'(DEPTH - 1)) begin
                           wr_n       = 1'b1;
                           wre_n.addr = addr_q;
                           wre_n.data = byte_nxt;
                        end else begin
                           oerr_n = 1'b1;
                           drop_n = 1'b1;
                        end
                     end
                  end else begin
                     sh_n = byte_nxt;
                  end
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         sh_q         <= '0;
         bit_q        <= '0;
         ph_q         <= '0;
         drop_q       <= 1'b0;
         wr_q         <= 1'b0;
         wre_q        <= '0;
         err_protocol <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         state_q      <= state_n;
         addr_q       <= addr_n;
         sh_q         <= sh_n;
         bit_q        <= bit_n;
         ph_q         <= ph_n;
         drop_q       <= drop_n;
         wr_q         <= wr_n;
         wre_q        <= wre_n;
         err_protocol <= perr_n;
         err_overflow <= oerr_n;
      end
   end

   router_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_q),
      .wr_entry (wre_q),
      .rd_en    (rx.out_ready),
      .rd_entry (head),
      .empty    (empty),
      .count    (count)
   );

   always_comb begin
      busy         = (state_q != IDLE);
      out_e        = empty ? '0 : head;
      rx.out_valid = ~empty;
      rx.out_addr  = out_e.addr;
      rx.out_data  = out_e.data;
      rx.out_last  = out_e.last;
      rx.out_err   = out_e.err;
   end

endmodule

// File: tb/tb_router_input_deserializer.sv
// Directed bench for router_input_deserializer: serial packets in, tagged byte entries out.
module tb_router_input_deserializer;
   import router_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic din;
   logic frame_n;
   logic valid_n;
   logic busy;
   logic err_protocol;
   logic err_overflow;

   router_input_deserializer_if rx_if ();

   router_input_deserializer #(
      .DEPTH      (8),
      .PAD_CYCLES (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .frame_n      (frame_n),
      .valid_n      (valid_n),
      .rx           (rx_if),
      .busy         (busy),
      .err_protocol (err_protocol),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   int        n_cmp = 0;
   int        n_mis = 0;
   rx_entry_t cap [64];
   int        cap_n = 0;
   int        perr_cnt = 0;
   int        oerr_cnt = 0;

   // Accepted entries and error pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_if.out_valid && rx_if.out_ready && cap_n < 64) begin
         cap[cap_n[5:0]] <= {rx_if.out_addr, rx_if.out_data, rx_if.out_last, rx_if.out_err};
         cap_n           <= cap_n + 1;
      end
      if (err_protocol) perr_cnt <= perr_cnt + 1;
      if (err_overflow) oerr_cnt <= oerr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic d, input logic f, input logic v);
      din     = d;
      frame_n = f;
      valid_n = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1);
   endtask

   task automatic send_pkt(input logic [3:0] a, input logic [127:0] pl, input int nbits,
                           input int stall_at, input int stall_len, input bit lat_chk);
      for (int i = 0; i < 4; i++) step(a[i], 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < nbits; i++) begin
         if (i == stall_at)
            for (int s = 0; s < stall_len; s++) step(1'b1, 1'b1, 1'b1);
         step(pl[i], (i == nbits - 1), 1'b0);
         if (lat_chk && i == 7) check("lat_edge_k_valid", rx_if.out_valid, 0);
         if (lat_chk && i == 8) begin
            check("lat_edge_k1_valid", rx_if.out_valid, 1);
            check("lat_edge_k1_data", rx_if.out_data, 8'h3C);
         end
      end
      step(1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int             base;
      int             p0;
      int             o0;
      logic [127:0]   pl;

      reset           = 1'b1;
      din             = 1'b0;
      frame_n         = 1'b1;
      valid_n         = 1'b1;
      rx_if.out_ready = 1'b0;
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      reset = 1'b0;

      check("rst_valid", rx_if.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", {rx_if.out_addr, rx_if.out_data, rx_if.out_last, rx_if.out_err}, 0);
      check("rst_errs", {err_protocol, err_overflow}, 0);

      // Two-byte packet, latency of first byte
      rx_if.out_ready = 1'b1;
      base = cap_n;
      send_pkt(4'hA, 128'hA53C, 16, -1, 0, 1'b1);
      idle(3);
      check("t1_count", cap_n - base, 2);
      check("t1_e0", cap[6'(base)], {4'hA, 8'h3C, 1'b0, 1'b0});
      check("t1_e1", cap[6'(base + 1)], {4'hA, 8'hA5, 1'b1, 1'b0});

      // 12-bit payload: partial final byte is flagged
      base = cap_n;
      send_pkt(4'h2, 128'h5FF, 12, -1, 0, 1'b0);
      idle(3);
      check("t2_count", cap_n - base, 2);
      check("t2_e0", cap[6'(base)], {4'h2, 8'hFF, 1'b0, 1'b0});
      check("t2_e1", cap[6'(base + 1)], {4'h2, 8'h05, 1'b1, 1'b1});

      // Stalls mid-byte (frame_n high during stalls must be ignored)
      base = cap_n;
      send_pkt(4'h5, 128'h81, 8, 3, 3, 1'b0);
      idle(3);
      check("t3_count", cap_n - base, 1);
      check("t3_e0", cap[6'(base)], {4'h5, 8'h81, 1'b1, 1'b0});

      // frame_n rises during PAD
      base = cap_n;
      p0   = perr_cnt;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("t4_busy_pad", busy, 1);
      step(1'b0, 1'b1, 1'b1);
      check("t4_busy_after", busy, 0);
      check("t4_perr_pulse", err_protocol, 1);
      idle(2);
      check("t4_perr_gone", err_protocol, 0);
      check("t4_perr_count", perr_cnt - p0, 1);
      check("t4_no_entry", cap_n - base, 0);
      check("t4_valid", rx_if.out_valid, 0);
      send_pkt(4'h7, 128'h42, 8, -1, 0, 1'b0);
      idle(3);
      check("t4_next_count", cap_n - base, 1);
      check("t4_next_e0", cap[6'(base)], {4'h7, 8'h42, 1'b1, 1'b0});

      // 10-byte packet into a stalled FIFO
      rx_if.out_ready = 1'b0;
      base = cap_n;
      o0   = oerr_cnt;
      pl   = '0;
      for (int j = 0; j < 10; j++) pl[j*8 +: 8] = 8'(j + 1);
      send_pkt(4'h9, pl, 80, -1, 0, 1'b0);
      idle(2);
      check("t5_oerr_count", oerr_cnt - o0, 1);
      check("t5_head_valid", rx_if.out_valid, 1);
      check("t5_head", {rx_if.out_addr, rx_if.out_data, rx_if.out_last, rx_if.out_err},
            {4'h9, 8'h01, 1'b0, 1'b0});
      rx_if.out_ready = 1'b1;
      idle(12);
      check("t5_count", cap_n - base, 8);
      for (int j = 0; j < 7; j++)
         check($sformatf("t5_e%0d", j), cap[6'(base + j)], {4'h9, 8'(j + 1), 1'b0, 1'b0});
      check("t5_term", cap[6'(base + 7)], {4'h9, 8'h0A, 1'b1, 1'b1});
      check("t5_empty", rx_if.out_valid, 0);

      // Reset after 13 data bits
      rx_if.out_ready = 1'b0;
      pl = 128'h1A5A;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 13; i++) step(pl[i], 1'b0, 1'b0);
      check("t6_pre_valid", rx_if.out_valid, 1);
      check("t6_pre_busy", busy, 1);
      reset = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      check("t6_rst_valid", rx_if.out_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_data", rx_if.out_data, 0);
      idle(1);
      rx_if.out_ready = 1'b1;
      base = cap_n;
      send_pkt(4'h3, 128'h1EC3, 16, -1, 0, 1'b0);
      idle(3);
      check("t6_count", cap_n - base, 2);
      check("t6_e0", cap[6'(base)], {4'h3, 8'hC3, 1'b0, 1'b0});
      check("t6_e1", cap[6'(base + 1)], {4'h3, 8'h1E, 1'b1, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
